// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and lane-offset width.
package lsu_pkg;

  localparam int LSU_WLEN   = 4;
  localparam int BYTE_OFS_W = $clog2(LSU_WLEN);

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    WR,
    RD,
    LD,
    RMW_RD,
    RMW_MRG,
    RMW_WR
  } state_e;

  // Misaligned or illegal access size for the given byte offset.
  function automatic logic misaligned(size_e size, logic [BYTE_OFS_W-1:0] ofs);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = ofs[0];
      SZ_W:    misaligned = (ofs != '0);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle and RAM-side port bundle of the load/store unit.
interface lsu_core_if #(
  parameter int DLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [31:0]     req_addr;
  logic [DLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_err;
  logic [DLEN-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

interface lsu_mem_if #(
  parameter int DLEN = 32,
  parameter int ALEN = 10
);
  logic            wvalid;
  logic [ALEN-1:0] waddr;
  logic [DLEN-1:0] wdata;
  logic            rvalid;
  logic [ALEN-1:0] raddr;
  logic [DLEN-1:0] rdata;

  modport master (
    output wvalid, waddr, wdata, rvalid, raddr,
    input  rdata
  );

  modport slave (
    input  wvalid, waddr, wdata, rvalid, raddr,
    output rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load extract with sign/zero extension, and sub-word store merge.
import lsu_pkg::*;

module lsu_lane_align #(
  parameter int BLEN = 8,
  parameter int WLEN = 4,
  parameter int DLEN = BLEN * WLEN
) (
  input  logic [DLEN-1:0]       word,
  input  logic [BYTE_OFS_W-1:0] lane,
  input  size_e                 size,
  input  logic                  is_unsigned,
  input  logic [DLEN-1:0]       wdata,
  output logic [DLEN-1:0]       load_data,
  output logic [DLEN-1:0]       merged
);

  localparam int HLEN = DLEN / 2;

  logic [BLEN-1:0] byte_sel;
  logic [HLEN-1:0] half_sel;

  always_comb begin
    byte_sel  = word[lane*BLEN +: BLEN];
    half_sel  = word[lane[1]*HLEN +: HLEN];
    load_data = word;
    case (size)
      SZ_B:    load_data = {{(DLEN-BLEN){~is_unsigned & byte_sel[BLEN-1]}}, byte_sel};
      SZ_H:    load_data = {{(DLEN-HLEN){~is_unsigned & half_sel[HLEN-1]}}, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SZ_B:    merged[lane*BLEN +: BLEN]    = wdata[BLEN-1:0];
      SZ_H:    merged[lane[1]*HLEN +: HLEN] = wdata[HLEN-1:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-organised dual-port RAM; sub-word stores use read-modify-write.
// Optional macro LSU_BOUNDS_CHECK_EN: addresses beyond MLEN words take the error path.
import lsu_pkg::*;

module load_store_unit #(
  parameter int BLEN = 8,
  parameter int WLEN = 4,
  parameter int DLEN = BLEN * WLEN,
  parameter int MLEN = 1024,
  parameter int ALEN = $clog2(MLEN)
) (
  input  logic      clk,
  input  logic      rst,
  lsu_core_if.slave core,
  lsu_mem_if.master mem
);

  state_e          state, state_nxt;
  logic            lat_we;
  size_e           lat_size;
  logic            lat_uns;
  logic [ALEN+1:0] lat_addr;
  logic [DLEN-1:0] lat_wdata;
  logic [DLEN-1:0] merged_q;

  logic [ALEN-1:0]       word_addr;
  logic [BYTE_OFS_W-1:0] lane;
  logic [DLEN-1:0]       load_data;
  logic [DLEN-1:0]       merged;
  logic                  accept;
  logic                  req_err;
  logic                  out_of_range;

  assign word_addr = lat_addr[ALEN+1:2];
  assign lane      = lat_addr[BYTE_OFS_W-1:0];
  assign accept    = core.req_valid && (state == IDLE);

`ifdef LSU_BOUNDS_CHECK_EN
  assign out_of_range = |core.req_addr[31:ALEN+2];
`else
  // Upper address bits are ignored, so the RAM wraps modulo MLEN words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^core.req_addr[31:ALEN+2];
  assign out_of_range   = 1'b0;
`endif

  assign req_err = misaligned(size_e'(core.req_size), core.req_addr[BYTE_OFS_W-1:0]) || out_of_range;

  lsu_lane_align #(
    .BLEN (BLEN),
    .WLEN (WLEN),
    .DLEN (DLEN)
  ) u_align (
    .word        (mem.rdata),
    .lane        (lane),
    .size        (lat_size),
    .is_unsigned (lat_uns),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the request and merge registers carry no reset; they are only read in states
  // that are entered after being loaded, so resetting them would just add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= core.req_we;
      lat_size  <= size_e'(core.req_size);
      lat_uns   <= core.req_unsigned;
      lat_addr  <= core.req_addr[ALEN+1:0];
      lat_wdata <= core.req_wdata;
    end
    if (state == RMW_MRG) merged_q <= merged;
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    core.req_ready = (state == IDLE);
    core.rsp_valid = 1'b0;
    core.rsp_err   = 1'b0;
    core.rsp_rdata = '0;
    mem.wvalid     = 1'b0;
    mem.waddr      = '0;
    mem.wdata      = '0;
    mem.rvalid     = 1'b0;
    mem.raddr      = '0;

    case (state)
      IDLE: begin
        if (core.req_valid) begin
          if (req_err)                          state_nxt = ERR;
          else if (!core.req_we)                state_nxt = RD;
          else if (size_e'(core.req_size) == SZ_W) state_nxt = WR;
          else                                  state_nxt = RMW_RD;
        end
      end
      ERR: begin
        core.rsp_valid = 1'b1;
        core.rsp_err   = 1'b1;
        state_nxt      = IDLE;
      end
      WR: begin
        mem.wvalid     = 1'b1;
        mem.waddr      = word_addr;
        mem.wdata      = lat_wdata;
        core.rsp_valid = 1'b1;
        state_nxt      = IDLE;
      end
      RD: begin
        mem.rvalid = 1'b1;
        mem.raddr  = word_addr;
        state_nxt  = LD;
      end
      LD: begin
        core.rsp_valid = 1'b1;
        core.rsp_rdata = load_data;
        state_nxt      = IDLE;
      end
      RMW_RD: begin
        mem.rvalid = 1'b1;
        mem.raddr  = word_addr;
        state_nxt  = RMW_MRG;
      end
      RMW_MRG: state_nxt = RMW_WR;
      RMW_WR: begin
        mem.wvalid     = 1'b1;
        mem.waddr      = word_addr;
        mem.wdata      = merged_q;
        core.rsp_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic unused_lat_we;
  assign unused_lat_we = lat_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural one-cycle-read RAM.
import lsu_pkg::*;

module tb_load_store_unit;

  localparam int ALEN = 10;
  localparam int MLEN = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_core_if #(.DLEN(32))              core ();
  lsu_mem_if  #(.DLEN(32), .ALEN(ALEN)) mem ();

  load_store_unit #(
    .BLEN (8),
    .WLEN (4),
    .DLEN (32),
    .MLEN (MLEN),
    .ALEN (ALEN)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core.slave),
    .mem  (mem.master)
  );

  logic [31:0] ram [MLEN];
  always @(posedge clk) begin
    if (mem.wvalid) ram[mem.waddr] <= mem.wdata;
    if (mem.rvalid) mem.rdata <= ram[mem.raddr];
  end

  int n_cmp = 0;
  int n_mis = 0;

  // Per-request trace: cycle numbers are counted from the accepting edge (0 = never seen).
  logic [3:0]      tr_rsp_cyc, tr_w_cyc, tr_r_cyc, tr_rdy_cyc;
  logic            tr_err, tr_bad;
  logic [31:0]     tr_rdata, tr_wdata;
  logic [ALEN-1:0] tr_waddr, tr_raddr;

  task automatic idle_inputs();
    core.req_valid    = 1'b0;
    core.req_we       = 1'b0;
    core.req_size     = 2'b00;
    core.req_unsigned = 1'b0;
    core.req_addr     = '0;
    core.req_wdata    = '0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int budget = 0;
    int n_rsp  = 0;
    @(negedge clk);
    while (!core.req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!core.req_ready) begin
      n_cmp++;
      n_mis++;
      $display("FAIL ready_timeout: req_ready=%b required 1", core.req_ready);
    end
    core.req_valid    = 1'b1;
    core.req_we       = we;
    core.req_size     = size;
    core.req_unsigned = uns;
    core.req_addr     = addr;
    core.req_wdata    = wdata;
    @(posedge clk);
    #1 idle_inputs();
    tr_rsp_cyc = 0; tr_w_cyc = 0; tr_r_cyc = 0; tr_rdy_cyc = 0;
    tr_err = 0; tr_bad = 0; tr_rdata = 0; tr_wdata = 0; tr_waddr = 0; tr_raddr = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (core.rsp_valid) begin
        n_rsp++;
        if (tr_rsp_cyc == 0) begin
          tr_rsp_cyc = 4'(c);
          tr_err     = core.rsp_err;
          tr_rdata   = core.rsp_rdata;
        end
      end
      if (mem.wvalid) begin
        tr_w_cyc = 4'(c);
        tr_waddr = mem.waddr;
        tr_wdata = mem.wdata;
      end
      if (mem.rvalid) begin
        tr_r_cyc = 4'(c);
        tr_raddr = mem.raddr;
      end
      if (core.req_ready && tr_rdy_cyc == 0) tr_rdy_cyc = 4'(c);
      if (mem.wvalid && mem.rvalid) tr_bad = 1;
      if (!mem.wvalid && (mem.waddr != 0 || mem.wdata != 0)) tr_bad = 1;
      if (!mem.rvalid && mem.raddr != 0) tr_bad = 1;
      if (!core.rsp_valid && (core.rsp_err || core.rsp_rdata != 0)) tr_bad = 1;
    end
    if (n_rsp > 1) tr_bad = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({core.rsp_valid, core.rsp_err, core.rsp_rdata, mem.wvalid, mem.waddr, mem.wdata,
         mem.rvalid, mem.raddr} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: rsp_v=%b err=%b rdata=%h wv=%b wa=%h wd=%h rv=%b ra=%h required all 0",
               core.rsp_valid, core.rsp_err, core.rsp_rdata, mem.wvalid, mem.waddr, mem.wdata,
               mem.rvalid, mem.raddr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (core.req_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_ready: req_ready=%b required 1", core.req_ready);
    end
  endtask

  task automatic test_word_store_load();
    issue(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF);
    n_cmp++;
    if ({tr_w_cyc, tr_waddr, tr_wdata} !== {4'd1, 10'd4, 32'hDEADBEEF}) begin
      n_mis++;
      $display("FAIL sw_write: cyc=%0d waddr=%0d wdata=%h required cyc=1 waddr=4 wdata=deadbeef",
               tr_w_cyc, tr_waddr, tr_wdata);
    end
    n_cmp++;
    if ({tr_rsp_cyc, tr_err, tr_rdata, tr_r_cyc, tr_rdy_cyc, tr_bad} !==
        {4'd1, 1'b0, 32'h0, 4'd0, 4'd2, 1'b0}) begin
      n_mis++;
      $display("FAIL sw_rsp: rsp_cyc=%0d err=%b rdata=%h rcyc=%0d rdy=%0d bad=%b required 1 0 0 0 2 0",
               tr_rsp_cyc, tr_err, tr_rdata, tr_r_cyc, tr_rdy_cyc, tr_bad);
    end
    issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    n_cmp++;
    if ({tr_r_cyc, tr_raddr, tr_w_cyc} !== {4'd1, 10'd4, 4'd0}) begin
      n_mis++;
      $display("FAIL lw_read: rcyc=%0d raddr=%0d wcyc=%0d required 1 4 0", tr_r_cyc, tr_raddr, tr_w_cyc);
    end
    n_cmp++;
    if ({tr_rsp_cyc, tr_err, tr_rdata, tr_rdy_cyc, tr_bad} !== {4'd2, 1'b0, 32'hDEADBEEF, 4'd3, 1'b0}) begin
      n_mis++;
      $display("FAIL lw_rsp: rsp_cyc=%0d err=%b rdata=%h rdy=%0d bad=%b required 2 0 deadbeef 3 0",
               tr_rsp_cyc, tr_err, tr_rdata, tr_rdy_cyc, tr_bad);
    end
  endtask

  task automatic test_subword_store();
    issue(1'b1, SZ_B, 1'b0, 32'h11, 32'hA5A5A555);
    n_cmp++;
    if ({tr_r_cyc, tr_raddr, tr_w_cyc, tr_waddr, tr_wdata} !== {4'd1, 10'd4, 4'd3, 10'd4, 32'hDEAD55EF}) begin
      n_mis++;
      $display("FAIL sb_rmw: rcyc=%0d raddr=%0d wcyc=%0d waddr=%0d wdata=%h required 1 4 3 4 dead55ef",
               tr_r_cyc, tr_raddr, tr_w_cyc, tr_waddr, tr_wdata);
    end
    n_cmp++;
    if ({tr_rsp_cyc, tr_err, tr_rdata, tr_bad} !== {4'd3, 1'b0, 32'h0, 1'b0}) begin
      n_mis++;
      $display("FAIL sb_rsp: rsp_cyc=%0d err=%b rdata=%h bad=%b required 3 0 0 0",
               tr_rsp_cyc, tr_err, tr_rdata, tr_bad);
    end
    issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    n_cmp++;
    if (tr_rdata !== 32'hDEAD55EF) begin
      n_mis++;
      $display("FAIL sb_readback: rdata=%h required dead55ef", tr_rdata);
    end
    issue(1'b1, SZ_H, 1'b0, 32'h12, 32'h1234BEEF);
    n_cmp++;
    if ({tr_w_cyc, tr_wdata} !== {4'd3, 32'hBEEF55EF}) begin
      n_mis++;
      $display("FAIL sh_merge: wcyc=%0d wdata=%h required 3 beef55ef", tr_w_cyc, tr_wdata);
    end
  endtask

  task automatic test_load_lanes();
    logic [1:0]  sz  [6] = '{SZ_B, SZ_B, SZ_H, SZ_H, SZ_B, SZ_B};
    logic        uns [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] adr [6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h11, 32'h12};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                             32'h00000000, 32'h000000FF};
    issue(1'b1, SZ_W, 1'b0, 32'h10, 32'h80FF0000);
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, sz[i], uns[i], adr[i], 32'h0);
      n_cmp++;
      if ({tr_rsp_cyc, tr_err, tr_rdata} !== {4'd2, 1'b0, exp[i]}) begin
        n_mis++;
        $display("FAIL load_lane_%0d: rsp_cyc=%0d err=%b rdata=%h required 2 0 %h",
                 i, tr_rsp_cyc, tr_err, tr_rdata, exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        we  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz  [4] = '{SZ_W, SZ_H, 2'b11, SZ_W};
    logic [31:0] adr [4] = '{32'h12, 32'h11, 32'h10, 32'h13};
    for (int i = 0; i < 4; i++) begin
      issue(we[i], sz[i], 1'b0, adr[i], 32'hFFFFFFFF);
      n_cmp++;
      if ({tr_rsp_cyc, tr_err, tr_rdata, tr_w_cyc, tr_r_cyc, tr_bad} !==
          {4'd1, 1'b1, 32'h0, 4'd0, 4'd0, 1'b0}) begin
        n_mis++;
        $display("FAIL error_%0d: rsp_cyc=%0d err=%b rdata=%h wcyc=%0d rcyc=%0d bad=%b required 1 1 0 0 0 0",
                 i, tr_rsp_cyc, tr_err, tr_rdata, tr_w_cyc, tr_r_cyc, tr_bad);
      end
    end
  endtask

  task automatic test_bounds();
    issue(1'b1, SZ_W, 1'b0, 32'h0, 32'hCAFEF00D);
    issue(1'b0, SZ_W, 1'b0, 32'h1000, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
    n_cmp++;
    if ({tr_rsp_cyc, tr_err, tr_rdata, tr_r_cyc} !== {4'd1, 1'b1, 32'h0, 4'd0}) begin
      n_mis++;
      $display("FAIL bounds_err: rsp_cyc=%0d err=%b rdata=%h rcyc=%0d required 1 1 0 0",
               tr_rsp_cyc, tr_err, tr_rdata, tr_r_cyc);
    end
`else
    n_cmp++;
    if ({tr_rsp_cyc, tr_err, tr_rdata, tr_r_cyc, tr_raddr} !== {4'd2, 1'b0, 32'hCAFEF00D, 4'd1, 10'd0}) begin
      n_mis++;
      $display("FAIL bounds_wrap: rsp_cyc=%0d err=%b rdata=%h rcyc=%0d raddr=%0d required 2 0 cafef00d 1 0",
               tr_rsp_cyc, tr_err, tr_rdata, tr_r_cyc, tr_raddr);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [5:0] w_mask = '0;
    logic [5:0] r_mask = '0;
    @(negedge clk);
    core.req_valid = 1'b1;
    core.req_we    = 1'b1;
    core.req_size  = SZ_W;
    core.req_addr  = 32'h40;
    core.req_wdata = 32'h11111111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      w_mask[c] = mem.wvalid;
      r_mask[c] = core.rsp_valid;
    end
    idle_inputs();
    n_cmp++;
    if ({w_mask, r_mask} !== {6'b010101, 6'b010101}) begin
      n_mis++;
      $display("FAIL back_to_back: wvalid_mask=%b rsp_mask=%b required 010101 010101", w_mask, r_mask);
    end
    n_cmp++;
    if (ram[16] !== 32'h11111111) begin
      n_mis++;
      $display("FAIL back_to_back_ram: word16=%h required 11111111", ram[16]);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int n_w   = 0;
    int n_rsp = 0;
    logic rdy_after;
    issue(1'b1, SZ_W, 1'b0, 32'h20, 32'h11223344);
    @(negedge clk);
    core.req_valid = 1'b1;
    core.req_we    = 1'b1;
    core.req_size  = SZ_H;
    core.req_addr  = 32'h20;
    core.req_wdata = 32'h0000AAAA;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    n_w += int'(mem.wvalid); n_rsp += int'(core.rsp_valid);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_w += int'(mem.wvalid); n_rsp += int'(core.rsp_valid);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    rdy_after = core.req_ready;
    for (int c = 0; c < 3; c++) begin
      n_w += int'(mem.wvalid); n_rsp += int'(core.rsp_valid);
      @(negedge clk);
    end
    n_cmp++;
    if ({n_w, n_rsp} !== {32'd0, 32'd0}) begin
      n_mis++;
      $display("FAIL rst_rmw_quiet: wvalids=%0d responses=%0d required 0 0", n_w, n_rsp);
    end
    n_cmp++;
    if (rdy_after !== 1'b1) begin
      n_mis++;
      $display("FAIL rst_rmw_ready: req_ready=%b required 1", rdy_after);
    end
    n_cmp++;
    if (ram[8] !== 32'h11223344) begin
      n_mis++;
      $display("FAIL rst_rmw_ram: word8=%h required 11223344", ram[8]);
    end
    issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    n_cmp++;
    if ({tr_rsp_cyc, tr_rdata} !== {4'd2, 32'h11223344}) begin
      n_mis++;
      $display("FAIL rst_rmw_readback: rsp_cyc=%0d rdata=%h required 2 11223344", tr_rsp_cyc, tr_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < MLEN; i++) ram[i] = '0;
    mem.rdata = '0;
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_load_lanes();
    test_errors();
    test_bounds();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
